// File: rtl/mux_arbiter_feed_pkg.sv
// Shared types for the mux feeder: data width and arbiter FSM state encoding.
// Imported by the channel buffer and the top-level arbiter.
package mux_arbiter_feed_pkg;

  localparam int MUX_DW = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  function automatic state_t grant_state(input logic ch);
    return ch ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/mux_chan_buf.sv
// One-entry valid/ready holding register; data is stored on the accepting edge.
// Latency: 1 edge. Backpressure: ready only when empty or being popped this cycle.
// Held while reset is asserted: ready is forced low.
module mux_chan_buf
  import mux_arbiter_feed_pkg::*;
#(
  parameter int DW = MUX_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          pop,
  output logic [DW-1:0] buf_data,
  output logic          full
);

  logic          full_q, full_d;
  logic [DW-1:0] data_q, data_d;
  logic          accept;

  always_comb begin
    in_ready = !rst && (!full_q || pop);
    accept   = in_valid && in_ready;
    full_d   = full_q;
    data_d   = data_q;
    if (pop) begin
      full_d = 1'b0;
    end
    // A refill in the same cycle as the pop wins: the slot stays occupied.
    if (accept) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign buf_data = data_q;
  assign full     = full_q;

endmodule

// File: rtl/mux_arbiter_feed.sv
// Two buffered valid/ready channels arbitrated onto a 2:1 mux with registered select.
// Latency: accept -> out_valid 2 edges, 1 word/cycle sustained; holds word while !out_ready.
// Tie policy: round-robin by default, channel 0 always wins with ARB_FIXED_PRIO_EN defined.
module mux_arbiter_feed
  import mux_arbiter_feed_pkg::*;
#(
  parameter int DW = MUX_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] in0_data,
  input  logic          in0_valid,
  output logic          in0_ready,
  input  logic [DW-1:0] in1_data,
  input  logic          in1_valid,
  output logic          in1_ready,
  output logic [DW-1:0] datain_0,
  output logic [DW-1:0] datain_1,
  output logic          select,
  output logic          out_valid,
  input  logic          out_ready
);

  state_t state_q, state_d;
  logic   select_q, select_d;
  logic   out_valid_q, out_valid_d;
  logic   last_grant_q, last_grant_d;

  logic   full0, full1, pop0, pop1, acc0, acc1;
  logic   decide, cand0, cand1, tie_last, tie_ch;

  assign pop0 = (state_q == GRANT0) && out_valid_q && out_ready;
  assign pop1 = (state_q == GRANT1) && out_valid_q && out_ready;
  assign acc0 = in0_valid && in0_ready;
  assign acc1 = in1_valid && in1_ready;

  mux_chan_buf #(.DW(DW)) u_buf0 (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in0_data),
    .in_valid (in0_valid),
    .in_ready (in0_ready),
    .pop      (pop0),
    .buf_data (datain_0),
    .full     (full0)
  );

  mux_chan_buf #(.DW(DW)) u_buf1 (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in1_data),
    .in_valid (in1_valid),
    .in_ready (in1_ready),
    .pop      (pop1),
    .buf_data (datain_1),
    .full     (full1)
  );

  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    last_grant_d = last_grant_q;
    decide       = 1'b0;
    cand0        = 1'b0;
    cand1        = 1'b0;
    tie_last     = last_grant_q;
    case (state_q)
      IDLE: begin
        decide = 1'b1;
        cand0  = full0;
        cand1  = full1;
      end
      // On completion the finishing channel only competes if it was refilled this cycle.
      GRANT0: if (out_ready) begin
        decide       = 1'b1;
        last_grant_d = 1'b0;
        tie_last     = 1'b0;
        cand0        = acc0;
        cand1        = full1;
      end
      GRANT1: if (out_ready) begin
        decide       = 1'b1;
        last_grant_d = 1'b1;
        tie_last     = 1'b1;
        cand0        = full0;
        cand1        = acc1;
      end
      default: decide = 1'b1;
    endcase

`ifdef ARB_FIXED_PRIO_EN
    tie_ch = 1'b0;
`else
    tie_ch = !tie_last;
`endif

    if (decide) begin
      if (cand0 && cand1) begin
        state_d = grant_state(tie_ch);
      end else if (cand0) begin
        state_d = GRANT0;
      end else if (cand1) begin
        state_d = GRANT1;
      end else begin
        state_d = IDLE;
      end
    end

    // select only moves on grant edges and keeps its last value through IDLE.
    if (state_d == GRANT0) begin
      select_d = 1'b0;
    end else if (state_d == GRANT1) begin
      select_d = 1'b1;
    end
    out_valid_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      select_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      select_q     <= select_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign select    = select_q;
  assign out_valid = out_valid_q;

endmodule
